// File: rtl/mfilter_pkg.sv
// Shared constants, FSM encoding and write-address helper for the
// matched-filter configuration controller.
package mfilter_pkg;

  localparam int NUM_WORDS    = 14;
  localparam int MAX_LEN      = 192;
  localparam int BLANK_CYCLES = 16;
  localparam int COUNT_W      = 16;

  localparam logic [3:0] CSTATE_LEN = 4'd1;
  localparam logic [3:0] CSTATE_THR = 4'd2;
  localparam logic [3:0] CSTATE_CO0 = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DISCARD,
    ST_BLANK
  } state_t;

  // Filter write address for packet word idx: length, threshold, then coefficients.
  function automatic logic [3:0] cstate_of(input logic [3:0] idx);
    case (idx)
      4'd0:    return CSTATE_LEN;
      4'd1:    return CSTATE_THR;
      default: return CSTATE_CO0 + (idx - 4'd2);
    endcase
  endfunction

endpackage

// File: rtl/mfilter_match_counter.sv
// Registers the qualified match decision and keeps a saturating count of
// qualified matches with a synchronous clear.
module mfilter_match_counter
  import mfilter_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               qualify,
  input  logic               clear_count,
  output logic               match_pulse,
  output logic [COUNT_W-1:0] match_count
);

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
  localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_pulse <= 1'b0;
      match_count <= '0;
    end else begin
      match_pulse <= qualify;
      // A clear that lands on a qualifying match keeps that match.
      if (clear_count)
        match_count <= qualify ? COUNT_ONE : '0;
      else if (qualify && (match_count != COUNT_MAX))
        match_count <= match_count + COUNT_ONE;
    end
  end

endmodule

// File: rtl/mfilter_ctrl.sv
// Configuration sequencer and result gate: replays a configuration packet as
// single-cycle filter writes and gates decisions made with stale coefficients.
module mfilter_ctrl #(
  parameter int NUM_WORDS    = mfilter_pkg::NUM_WORDS,
  parameter int MAX_LEN      = mfilter_pkg::MAX_LEN,
  parameter int BLANK_CYCLES = mfilter_pkg::BLANK_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cfg_data,
  input  logic        cfg_valid,
  input  logic        cfg_last,
  output logic        cfg_ready,
  output logic [31:0] cdata,
  output logic [3:0]  cstate,
  output logic        cwrite,
  input  logic        mf_valid,
  input  logic        mf_match,
  input  logic        clear_count,
  output logic        match_pulse,
  output logic [15:0] match_count,
  output logic        cfg_loaded,
  output logic        cfg_error,
  output logic        busy
);

  import mfilter_pkg::state_t;
  import mfilter_pkg::ST_IDLE;
  import mfilter_pkg::ST_LOAD;
  import mfilter_pkg::ST_DISCARD;
  import mfilter_pkg::ST_BLANK;
  import mfilter_pkg::cstate_of;

  localparam logic [3:0]     LAST_IDX  = 4'(NUM_WORDS - 1);
  localparam int             BCW       = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BCW-1:0] BLANK_END = BCW'(BLANK_CYCLES - 1);

  state_t         state, state_d;
  logic [3:0]     idx, idx_d, word_idx;
  logic [BCW-1:0] blank_cnt, blank_d;
  logic           accept, len_bad;
  logic           wr_d, err_d, load_start, load_done;
  logic           qualify;

  assign accept   = cfg_valid & cfg_ready;
  assign len_bad  = (cfg_data == 32'd0) || (cfg_data > 32'(MAX_LEN));
  assign word_idx = (state == ST_IDLE) ? 4'd0 : idx;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      blank_cnt <= '0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      blank_cnt <= blank_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement leaves a variable unassigned and infers a latch.
  always_comb begin
    state_d    = state;
    idx_d      = idx;
    blank_d    = blank_cnt;
    wr_d       = 1'b0;
    err_d      = 1'b0;
    load_start = 1'b0;
    load_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          idx_d = '0;
          if (len_bad) begin
            err_d   = 1'b1;
            state_d = cfg_last ? ST_IDLE : ST_DISCARD;
          end else begin
            wr_d       = 1'b1;
            load_start = 1'b1;
            idx_d      = 4'd1;
            if (cfg_last) begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_LOAD;
            end
          end
        end
      end
      ST_LOAD: begin
        if (accept) begin
          wr_d  = 1'b1;
          idx_d = idx + 4'd1;
          if (idx == LAST_IDX) begin
            if (cfg_last) begin
              state_d = ST_BLANK;
              blank_d = '0;
            end else begin
              err_d   = 1'b1;
              state_d = ST_DISCARD;
            end
          end else if (cfg_last) begin
            // Partial packet: the filter now holds a mixed configuration.
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_DISCARD: begin
        if (accept && cfg_last) state_d = ST_IDLE;
      end
      ST_BLANK: begin
        if (blank_cnt == BLANK_END) begin
          state_d   = ST_IDLE;
          load_done = 1'b1;
        end else begin
          blank_d = blank_cnt + BCW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_ready  <= 1'b0;
      cwrite     <= 1'b0;
      cstate     <= '0;
      cdata      <= '0;
      cfg_error  <= 1'b0;
      cfg_loaded <= 1'b0;
    end else begin
      cfg_ready <= (state_d != ST_BLANK);
      cwrite    <= wr_d;
      cfg_error <= err_d;
      if (wr_d) begin
        cstate <= cstate_of(word_idx);
        cdata  <= cfg_data;
      end
      if (load_start)
        cfg_loaded <= 1'b0;
      else if (load_done)
        cfg_loaded <= 1'b1;
    end
  end

  // Decisions are only trusted once the new coefficients have flushed through.
  assign qualify = mf_valid & mf_match & cfg_loaded & (state != ST_BLANK);

  mfilter_match_counter u_match (
    .clk         (clk),
    .reset       (reset),
    .qualify     (qualify),
    .clear_count (clear_count),
    .match_pulse (match_pulse),
    .match_count (match_count)
  );

endmodule

// File: tb/tb_mfilter_ctrl.sv
// Self-checking bench for mfilter_ctrl: packet-level reference model for the
// write stream and status flags, cycle model for the match counter.
module tb_mfilter_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] cfg_data;
  logic        cfg_valid;
  logic        cfg_last;
  logic        cfg_ready;
  logic [31:0] cdata;
  logic [3:0]  cstate;
  logic        cwrite;
  logic        mf_valid;
  logic        mf_match;
  logic        clear_count;
  logic        match_pulse;
  logic [15:0] match_count;
  logic        cfg_loaded;
  logic        cfg_error;
  logic        busy;

  mfilter_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_data    (cfg_data),
    .cfg_valid   (cfg_valid),
    .cfg_last    (cfg_last),
    .cfg_ready   (cfg_ready),
    .cdata       (cdata),
    .cstate      (cstate),
    .cwrite      (cwrite),
    .mf_valid    (mf_valid),
    .mf_match    (mf_match),
    .clear_count (clear_count),
    .match_pulse (match_pulse),
    .match_count (match_count),
    .cfg_loaded  (cfg_loaded),
    .cfg_error   (cfg_error),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic        model_loaded;
  logic [15:0] model_count;

  // Monitor: records every filter write, error pulse and loaded rising edge.
  int          cyc = 0;
  logic [3:0]  wr_state_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int          err_seen = 0;
  int          loaded_rise_cyc = 0;
  logic        loaded_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (cwrite) begin
        wr_state_q.push_back(cstate);
        wr_data_q.push_back(cdata);
        wr_cyc_q.push_back(cyc);
      end
      if (cfg_error) err_seen <= err_seen + 1;
      if (cfg_loaded && !loaded_prev) loaded_rise_cyc <= cyc;
    end
    loaded_prev <= cfg_loaded;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one word and returns just after the edge that accepted it.
  task automatic send_word(input logic [31:0] d, input bit last);
    int waited;
    waited = 0;
    @(negedge clk);
    cfg_data  = d;
    cfg_last  = last;
    cfg_valid = 1'b1;
    while (!cfg_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!cfg_ready) check("ready_timeout", 32'(cfg_ready), 32'd1);
    else @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  // Packet-level reference: what the filter should see and how status ends up.
  task automatic run_packet(input string tag, input logic [31:0] w[$], input int gap_max);
    int base, ebase, exp_n, exp_err, got_n;
    bit bad;
    base  = wr_state_q.size();
    ebase = err_seen;
    bad   = (w[0] == 32'd0) || (w[0] > 32'd192);
    if (bad) begin
      exp_n   = 0;
      exp_err = 1;
    end else begin
      exp_n        = (w.size() < 14) ? w.size() : 14;
      exp_err      = (w.size() == 14) ? 0 : 1;
      model_loaded = (w.size() == 14);
    end
    for (int i = 0; i < w.size(); i++) begin
      repeat (int'($urandom_range(0, gap_max))) @(negedge clk);
      send_word(w[i], i == w.size() - 1);
    end
    repeat (24) @(negedge clk);
    got_n = wr_state_q.size() - base;
    check({tag, "_nwr"}, 32'(got_n), 32'(exp_n));
    for (int k = 0; k < exp_n && k < got_n; k++) begin
      check($sformatf("%s_cs%0d", tag, k), 32'(wr_state_q[base+k]), 32'(k + 1));
      check($sformatf("%s_cd%0d", tag, k), wr_data_q[base+k], w[k]);
    end
    check({tag, "_err"}, 32'(err_seen - ebase), 32'(exp_err));
    check({tag, "_loaded"}, 32'(cfg_loaded), 32'(model_loaded));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ready"}, 32'(cfg_ready), 32'd1);
  endtask

  // Random decision traffic while the configuration status is steady.
  task automatic run_matches(input int n, input int clr_pct);
    logic q, exp_p;
    exp_p = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("m_pulse", 32'(match_pulse), 32'(exp_p));
        check("m_count", 32'(match_count), 32'(model_count));
      end
      mf_valid    = ($urandom_range(0, 3) != 0);
      mf_match    = ($urandom_range(0, 3) != 0);
      clear_count = ($urandom_range(0, 99) < clr_pct);
      q     = mf_valid & mf_match & model_loaded;
      exp_p = q;
      if (clear_count)                    model_count = q ? 16'd1 : 16'd0;
      else if (q && model_count != 16'hFFFF) model_count = model_count + 16'd1;
    end
    @(negedge clk);
    check("m_pulse_end", 32'(match_pulse), 32'(exp_p));
    check("m_count_end", 32'(match_count), 32'(model_count));
    mf_valid    = 1'b0;
    mf_match    = 1'b0;
    clear_count = 1'b0;
  endtask

  function automatic logic [31:0] rand_len_word();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd193;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd192;
      4:       return 32'd1;
      default: return 32'($urandom_range(1, 192));
    endcase
  endfunction

  initial begin
    logic [31:0] w[$];
    int base, ebase;

    cfg_data = '0; cfg_valid = 1'b0; cfg_last = 1'b0;
    mf_valid = 1'b0; mf_match = 1'b0; clear_count = 1'b0;
    model_loaded = 1'b0;
    model_count  = 16'd0;
    reset = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ready",  32'(cfg_ready),   32'd0);
    check("rst_cwrite", 32'(cwrite),      32'd0);
    check("rst_cstate", 32'(cstate),      32'd0);
    check("rst_cdata",  cdata,            32'd0);
    check("rst_pulse",  32'(match_pulse), 32'd0);
    check("rst_count",  32'(match_count), 32'd0);
    check("rst_loaded", 32'(cfg_loaded),  32'd0);
    check("rst_error",  32'(cfg_error),   32'd0);
    check("rst_busy",   32'(busy),        32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(cfg_ready), 32'd1);

    // Length 0 followed by 13 words: all discarded, one error
    w = {};
    w.push_back(32'd0);
    for (int i = 1; i < 14; i++) w.push_back($urandom);
    run_packet("len0", w, 0);

    // Legal 192-length packet back to back, decisions held through blanking
    w = {};
    w.push_back(32'd192);
    for (int i = 1; i < 14; i++) w.push_back($urandom);
    base  = wr_state_q.size();
    ebase = err_seen;
    for (int i = 0; i < 14; i++) send_word(w[i], i == 13);
    mf_valid = 1'b1;
    mf_match = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      check($sformatf("blk_pulse%0d", i),  32'(match_pulse), 32'(i >= 18));
      check($sformatf("blk_ready%0d", i),  32'(cfg_ready),   32'(i >= 17));
      check($sformatf("blk_busy%0d", i),   32'(busy),        32'(i <= 16));
      check($sformatf("blk_loaded%0d", i), 32'(cfg_loaded),  32'(i >= 17));
      if (i >= 2) check($sformatf("blk_count%0d", i), 32'(match_count), 32'((i >= 18) ? i - 17 : 0));
      clear_count = (i == 1);
    end
    mf_valid = 1'b0;
    mf_match = 1'b0;
    model_loaded = 1'b1;
    model_count  = 16'd3;
    check("legal_nwr", 32'(wr_state_q.size() - base), 32'd14);
    if (wr_state_q.size() - base >= 14) begin
      for (int k = 0; k < 14; k++) begin
        check($sformatf("legal_cs%0d", k), 32'(wr_state_q[base+k]), 32'(k + 1));
        check($sformatf("legal_cd%0d", k), wr_data_q[base+k], w[k]);
      end
      check("legal_span", 32'(wr_cyc_q[base+13] - wr_cyc_q[base]), 32'd13);
      check("legal_blank_len", 32'(loaded_rise_cyc - wr_cyc_q[base+13]), 32'd16);
    end
    check("legal_err", 32'(err_seen - ebase), 32'd0);

    run_matches(300, 5);

    // Saturation and clear-with-match
    @(negedge clk);
    mf_valid = 1'b1; mf_match = 1'b1; clear_count = 1'b1;
    @(negedge clk);
    clear_count = 1'b0;
    check("sat_clear_start", 32'(match_count), 32'd1);
    repeat (65533) @(negedge clk);
    check("sat_fffe", 32'(match_count), 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("sat_ffff%0d", i), 32'(match_count), 32'hFFFF);
    end
    clear_count = 1'b1;
    @(negedge clk);
    check("clear_with_match", 32'(match_count), 32'd1);
    mf_valid = 1'b0; mf_match = 1'b0; clear_count = 1'b0;
    model_count = 16'd1;

    // cfg_last on word 5: six writes, error, nothing loaded
    w = {};
    w.push_back(32'd64);
    for (int i = 1; i < 6; i++) w.push_back($urandom);
    run_packet("short6", w, 1);

    run_matches(150, 5);

    // Reset while the packet is mid-flight
    w = {};
    w.push_back(32'd100);
    for (int i = 1; i < 7; i++) w.push_back($urandom);
    for (int i = 0; i < 7; i++) send_word(w[i], 1'b0);
    check("midrst_pre_cwrite", 32'(cwrite), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_cwrite", 32'(cwrite),      32'd0);
    check("midrst_cstate", 32'(cstate),      32'd0);
    check("midrst_cdata",  cdata,            32'd0);
    check("midrst_ready",  32'(cfg_ready),   32'd0);
    check("midrst_busy",   32'(busy),        32'd0);
    check("midrst_count",  32'(match_count), 32'd0);
    model_loaded = 1'b0;
    model_count  = 16'd0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_ready_after", 32'(cfg_ready), 32'd1);
    w = {};
    w.push_back(32'($urandom_range(1, 192)));
    for (int i = 1; i < 14; i++) w.push_back($urandom);
    run_packet("fresh", w, 0);

    // Randomized packets: lengths, truncation, overrun, gaps
    for (int p = 0; p < 25; p++) begin
      int n;
      n = ($urandom_range(0, 1) != 0) ? 14 : int'($urandom_range(1, 16));
      w = {};
      w.push_back(rand_len_word());
      for (int i = 1; i < n; i++) w.push_back($urandom);
      run_packet($sformatf("rnd%0d", p), w, 2);
    end

    run_matches(300, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
